// File: rtl/prefix_adder_pipe.sv
`timescale 1ns/1ps
// Pipelined Kogge-Stone adder/subtractor with valid/ready on both sides and a tag sideband.
// Stage 0 holds bit-level generate/propagate; each later stage adds LVL_PER_STG prefix levels.
module prefix_adder_pipe #(
    parameter int WIDTH       = 64,
    parameter int LVL_PER_STG = 2,
    parameter int TAG_W       = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic [TAG_W-1:0] out_tag
);
    localparam int LOG2 = $clog2(WIDTH);
    localparam int LAT  = (LOG2 + LVL_PER_STG - 1) / LVL_PER_STG;
    localparam int NSTG = LAT + 1;
    localparam int LAST = NSTG - 1;

    // Index j of g/p is bit j-1; index 0 is the carry-in posing as bit -1.
    // After the last prefix level, g[j] is the carry into bit j.
    logic             v_q   [NSTG];
    logic [WIDTH-1:0] g_q   [NSTG];
    logic [WIDTH-1:0] p_q   [NSTG];
    logic [WIDTH-1:0] hp_q  [NSTG];
    logic             gm_q  [NSTG];
    logic [TAG_W-1:0] tag_q [NSTG];

    logic             v_d   [NSTG];
    logic [WIDTH-1:0] g_d   [NSTG];
    logic [WIDTH-1:0] p_d   [NSTG];
    logic [WIDTH-1:0] hp_d  [NSTG];
    logic             gm_d  [NSTG];
    logic [TAG_W-1:0] tag_d [NSTG];

    logic             rdy   [NSTG];
    logic             rdy_acc;
    logic [WIDTH-1:0] b_eff;
    logic             c_eff;
    logic [WIDTH-1:0] gt;
    logic [WIDTH-1:0] pt;
    logic             c_msb;

    // Handshake: a stage loads when it is empty or its content moves on this cycle;
    // the last stage moves on out_ready. Data transfers when valid & ready in the same cycle.
    always_comb begin : ready_chain
        rdy_acc = out_ready;
        for (int s = LAST; s >= 0; s--) begin
            rdy_acc = rdy_acc | ~v_q[s];
            rdy[s]  = rdy_acc;
        end
    end

    assign in_ready = rdy[0];

    always_comb begin : stage_logic
        b_eff    = in_sub ? ~in_b : in_b;
        c_eff    = in_sub | in_cin;
        v_d[0]   = in_valid;
        g_d[0]   = {in_a[WIDTH-2:0] & b_eff[WIDTH-2:0], c_eff};
        p_d[0]   = {in_a[WIDTH-2:0] ^ b_eff[WIDTH-2:0], 1'b0};
        hp_d[0]  = in_a ^ b_eff;
        gm_d[0]  = in_a[WIDTH-1] & b_eff[WIDTH-1];
        tag_d[0] = in_tag;
        gt       = '0;
        pt       = '0;
        for (int s = 1; s < NSTG; s++) begin
            gt = g_q[s-1];
            pt = p_q[s-1];
            for (int l = 0; l < LOG2; l++) begin
                if (l / LVL_PER_STG == s - 1) begin
                    // Descending j so g/p[j - 2^l] is still the previous level's value.
                    for (int j = WIDTH - 1; j >= (1 << l); j--) begin
                        gt[j] = gt[j] | (pt[j] & gt[j - (1 << l)]);
                        pt[j] = pt[j] & pt[j - (1 << l)];
                    end
                end
            end
            v_d[s]   = v_q[s-1];
            g_d[s]   = gt;
            p_d[s]   = pt;
            hp_d[s]  = hp_q[s-1];
            gm_d[s]  = gm_q[s-1];
            tag_d[s] = tag_q[s-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < NSTG; s++) begin
                v_q[s]   <= 1'b0;
                g_q[s]   <= '0;
                p_q[s]   <= '0;
                hp_q[s]  <= '0;
                gm_q[s]  <= 1'b0;
                tag_q[s] <= '0;
            end
        end else begin
            for (int s = 0; s < NSTG; s++) begin
                if (rdy[s]) begin
                    v_q[s] <= v_d[s];
                    if (v_d[s]) begin
                        g_q[s]   <= g_d[s];
                        p_q[s]   <= p_d[s];
                        hp_q[s]  <= hp_d[s];
                        gm_q[s]  <= gm_d[s];
                        tag_q[s] <= tag_d[s];
                    end
                end
            end
        end
    end

    assign c_msb     = g_q[LAST][WIDTH-1];
    assign out_valid = v_q[LAST];
    assign out_sum   = hp_q[LAST] ^ g_q[LAST];
    assign out_cout  = gm_q[LAST] | (hp_q[LAST][WIDTH-1] & c_msb);
    assign out_ovf   = c_msb ^ out_cout;
    assign out_tag   = tag_q[LAST];

endmodule

// File: tb/tb_prefix_adder_pipe.sv
`timescale 1ns/1ps
// Bench for prefix_adder_pipe (WIDTH=64, LVL_PER_STG=2): directed vectors, streaming,
// backpressure, random handshakes and mid-flight reset, all against a queue-based scoreboard.
module tb_prefix_adder_pipe;
    localparam int W    = 64;
    localparam int LPS  = 2;
    localparam int TW   = 4;
    localparam int LAT  = 3;
    localparam int NSTG = LAT + 1;
    localparam int RW   = W + 2 + TW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic          in_cin;
    logic          in_sub;
    logic [TW-1:0] in_tag;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_sum;
    logic          out_cout;
    logic          out_ovf;
    logic [TW-1:0] out_tag;

    always #5 clk = ~clk;

    prefix_adder_pipe #(.WIDTH(W), .LVL_PER_STG(LPS), .TAG_W(TW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf), .out_tag(out_tag)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [RW-1:0] exp_q[$];

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } vec_t;
    vec_t vt[10];

    function automatic logic [RW-1:0] model(logic [W-1:0] a, logic [W-1:0] b, logic cin,
                                            logic sub, logic [TW-1:0] tag);
        logic [W-1:0] be;
        logic [W:0]   full;
        logic         ovf;
        be   = sub ? ~b : b;
        full = {1'b0, a} + {1'b0, be} + {{W{1'b0}}, (sub | cin)};
        ovf  = (a[W-1] == be[W-1]) && (full[W-1] != a[W-1]);
        return {full[W-1:0], full[W], ovf, tag};
    endfunction

    function automatic logic [W-1:0] rnd_word();
        case ($urandom_range(0, 7))
            0:       return '1;
            1:       return '0;
            2:       return {1'b1, {(W-1){1'b0}}};
            default: return {$urandom, $urandom};
        endcase
    endfunction

    task automatic check(string name, logic [127:0] got, logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(logic [W-1:0] a, logic [W-1:0] b, logic cin, logic sub,
                         logic [TW-1:0] tag);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
        in_sub   = sub;
        in_tag   = tag;
    endtask

    task automatic drain(string name);
        int cyc;
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 100) begin
            tick();
            cyc++;
        end
        check(name, 128'(exp_q.size()), 128'(0));
    endtask

    // Scoreboard: sampled mid-cycle, reflects the transfers of the next rising edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL sb_unexpected: got %0h expected none",
                             {out_sum, out_cout, out_ovf, out_tag});
                end else begin
                    check("sb_result", 128'({out_sum, out_cout, out_ovf, out_tag}),
                          128'(exp_q.pop_front()));
                end
            end
            if (in_valid && in_ready)
                exp_q.push_back(model(in_a, in_b, in_cin, in_sub, in_tag));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc;
        int stalls;
        int gaps;
        int acc;
        logic [TW-1:0] tg;

        vt[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0};
        vt[1] = '{64'h0, 64'h1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0};
        vt[2] = '{64'h8000_0000_0000_0000, 64'h1, 1'b0, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};
        vt[3] = '{64'h0, 64'h0, 1'b1, 1'b0, 64'h1, 1'b0, 1'b0};
        vt[4] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
        vt[5] = '{64'h5, 64'h3, 1'b0, 1'b1, 64'h2, 1'b1, 1'b0};
        vt[6] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 64'h0, 1'b1, 1'b1};
        vt[7] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0,
                  64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0};
        vt[8] = '{64'h3, 64'h5, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
        vt[9] = '{64'h0, 64'h0, 1'b1, 1'b1, 64'h0, 1'b1, 1'b0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_cin    = 1'b0;
        in_sub    = 1'b0;
        in_tag    = '0;
        out_ready = 1'b0;
        repeat (2) tick();

        // Reset state
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_outputs", 128'({out_sum, out_cout, out_ovf, out_tag}), 128'(0));
        check("rst_in_ready", 128'(in_ready), 128'(1));
        rst_n = 1'b1;
        tick();

        // Directed vectors: value and exact latency
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(vt[i].a, vt[i].b, vt[i].cin, vt[i].sub, TW'(i));
            check("vec_in_ready", 128'(in_ready), 128'(1));
            tick();
            in_valid = 1'b0;
            cyc = 0;
            while (!out_valid && cyc < 20) begin
                tick();
                cyc++;
            end
            check("vec_latency", 128'(cyc), 128'(LAT));
            check("vec_result", 128'({out_sum, out_cout, out_ovf, out_tag}),
                  128'({vt[i].sum, vt[i].cout, vt[i].ovf, TW'(i)}));
            tick();
        end
        drain("vec_drain");

        // Back-to-back stream, consumer always ready
        stalls = 0;
        gaps   = 0;
        for (int i = 0; i < 100; i++) begin
            drive(rnd_word(), rnd_word(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  TW'(i));
            if (!in_ready) stalls++;
            tick();
            if (i >= LAT && !out_valid) gaps++;
        end
        in_valid = 1'b0;
        check("stream_stalls", 128'(stalls), 128'(0));
        check("stream_gaps", 128'(gaps), 128'(0));
        drain("stream_drain");

        // Backpressure: pipeline fills, holds, then releases in order
        out_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 12; i++) begin
            drive(rnd_word(), rnd_word(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  TW'(acc));
            if (in_ready) acc++;
            tick();
        end
        in_valid = 1'b0;
        check("fill_count", 128'(acc), 128'(NSTG));
        check("fill_in_ready", 128'(in_ready), 128'(0));
        for (int k = 0; k < 3; k++) begin
            check("stall_valid", 128'(out_valid), 128'(1));
            check("stall_hold", 128'({out_sum, out_cout, out_ovf, out_tag}), 128'(exp_q[0]));
            tick();
        end
        out_ready = 1'b1;
        drain("fill_drain");

        // Random valid/ready
        tg = '0;
        for (int i = 0; i < 2000; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            if (in_valid)
                drive(rnd_word(), rnd_word(), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), tg);
            out_ready = 1'($urandom_range(0, 1));
            if (in_valid && in_ready) tg++;
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain("rand_drain");

        // Reset with three results in flight
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(rnd_word(), rnd_word(), 1'b0, 1'b0, TW'(i));
            tick();
        end
        in_valid = 1'b0;
        check("pre_rst_pending", 128'(exp_q.size()), 128'(3));
        rst_n = 1'b0;
        #1;
        check("rst_async_valid", 128'(out_valid), 128'(0));
        exp_q.delete();
        tick();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        repeat (10) tick();
        check("post_rst_valid", 128'(out_valid), 128'(0));
        check("post_rst_in_ready", 128'(in_ready), 128'(1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
